// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline register-hazard scoreboard with stall/forward/pending decode
// Optional multiply/divide busy stall compiled in with `define HAZ_MDU_STALL_EN.
module hazard_scoreboard #(
  parameter int DEPTH   = 3,
  parameter int AW      = 5,
  parameter int TW      = 3,
  parameter int FW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_a1,
  input  logic [AW-1:0] d_a2,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_a3,
  input  logic [TW-1:0] d_tnew,
  input  logic          flush,
`ifdef HAZ_MDU_STALL_EN
  input  logic          d_isdm,
  input  logic          e_md_start,
  input  logic          e_md_div,
  output logic          md_busy,
`endif
  output logic          stall,
  output logic [FW-1:0] fwd_rs,
  output logic [FW-1:0] fwd_rt,
  output logic          pend_rs,
  output logic          pend_rt
);

  logic [DEPTH:1] e_valid;
  logic [AW-1:0]  e_a3  [DEPTH:1];
  logic [TW-1:0]  e_rem [DEPTH:1];

  logic          rs_req;
  logic          rt_req;
  logic          md_req;
  logic [TW-1:0] d_rem;

  assign d_rem = (d_tnew == '0) ? '0 : d_tnew - TW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        e_valid[k] <= 1'b0;
        e_a3[k]    <= '0;
        e_rem[k]   <= '0;
      end
    end else begin
      if (stall || flush) begin
        e_valid[1] <= 1'b0;
        e_a3[1]    <= '0;
        e_rem[1]   <= '0;
      end else begin
        e_valid[1] <= 1'b1;
        e_a3[1]    <= d_a3;
        e_rem[1]   <= d_rem;
      end
      for (int k = 2; k <= DEPTH; k++) begin
        e_valid[k] <= e_valid[k-1];
        e_a3[k]    <= e_a3[k-1];
        e_rem[k]   <= (e_rem[k-1] == '0) ? '0 : e_rem[k-1] - TW'(1);
      end
    end
  end

  // Scanning from oldest to youngest lets the youngest match overwrite older ones.
  function automatic void classify(
    input  logic [AW-1:0] addr,
    input  logic [TW-1:0] tuse,
    output logic          req,
    output logic [FW-1:0] fwd,
    output logic          pend
  );
    logic          hit;
    logic [TW-1:0] r;
    int            idx;
    hit = 1'b0;
    r   = '0;
    idx = 0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (e_valid[k] && (e_a3[k] == addr) && (addr != '0)) begin
        hit = 1'b1;
        r   = e_rem[k];
        idx = k;
      end
    end
    req  = hit && (r > tuse);
    fwd  = (hit && (r == '0)) ? FW'(idx) : '0;
    pend = hit && (r != '0) && (r <= tuse);
  endfunction

  always_comb begin
    rs_req  = 1'b0;
    rt_req  = 1'b0;
    fwd_rs  = '0;
    fwd_rt  = '0;
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    classify(d_a1, d_tuse_rs, rs_req, fwd_rs, pend_rs);
    classify(d_a2, d_tuse_rt, rt_req, fwd_rt, pend_rt);
  end

`ifdef HAZ_MDU_STALL_EN
  localparam int MAXLAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic [CW-1:0] md_cnt;

  // A new issue restarts the count even if the unit is still busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (e_md_start) begin
      md_cnt <= e_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy = (md_cnt != '0);
  assign md_req  = d_isdm & (md_busy | e_md_start);
`else
  assign md_req = 1'b0;
`endif

  assign stall = rs_req | rt_req | md_req;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_a1, d_a2, d_a3;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_rs, fwd_rt;
  logic       pend_rs, pend_rt;
`ifdef HAZ_MDU_STALL_EN
  logic       d_isdm, e_md_start, e_md_div, md_busy;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .d_a1      (d_a1),
    .d_a2      (d_a2),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_a3      (d_a3),
    .d_tnew    (d_tnew),
    .flush     (flush),
`ifdef HAZ_MDU_STALL_EN
    .d_isdm    (d_isdm),
    .e_md_start(e_md_start),
    .e_md_div  (e_md_div),
    .md_busy   (md_busy),
`endif
    .stall     (stall),
    .fwd_rs    (fwd_rs),
    .fwd_rt    (fwd_rt),
    .pend_rs   (pend_rs),
    .pend_rt   (pend_rt)
  );

  typedef struct {
    logic [4:0] a1, a2;
    logic [2:0] tu_rs, tu_rt;
    logic [4:0] a3;
    logic [2:0] tnew;
    logic       fl;
    logic       x_stall;
    logic [1:0] x_frs, x_frt;
    logic       x_prs, x_prt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] a1, input logic [2:0] tu_rs,
                              input logic [4:0] a2, input logic [2:0] tu_rt,
                              input logic [4:0] a3, input logic [2:0] tnew, input logic fl,
                              input logic xs, input logic [1:0] xfrs, input logic [1:0] xfrt,
                              input logic xprs, input logic xprt);
    vec_t v;
    v.a1 = a1; v.tu_rs = tu_rs; v.a2 = a2; v.tu_rt = tu_rt;
    v.a3 = a3; v.tnew = tnew; v.fl = fl;
    v.x_stall = xs; v.x_frs = xfrs; v.x_frt = xfrt; v.x_prs = xprs; v.x_prt = xprt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic xs, input logic [1:0] xfrs,
                         input logic [1:0] xfrt, input logic xprs, input logic xprt);
    chk({tag, ".stall"},   32'(stall),   32'(xs));
    chk({tag, ".fwd_rs"},  32'(fwd_rs),  32'(xfrs));
    chk({tag, ".fwd_rt"},  32'(fwd_rt),  32'(xfrt));
    chk({tag, ".pend_rs"}, 32'(pend_rs), 32'(xprs));
    chk({tag, ".pend_rt"}, 32'(pend_rt), 32'(xprt));
  endtask

  task automatic drive(input vec_t v);
    d_a1 = v.a1; d_tuse_rs = v.tu_rs; d_a2 = v.a2; d_tuse_rt = v.tu_rt;
    d_a3 = v.a3; d_tnew = v.tnew; flush = v.fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(mk(0,0, 0,0, 0,0,0, 0,0,0,0,0));
`ifdef HAZ_MDU_STALL_EN
    d_isdm = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
`endif

    //           a1 tu  a2 tu  a3 tn fl  st frs frt prs prt
    // load-use
    vecs.push_back(mk(0,0,  0,0,  8,3,0,  0,0,0,0,0));
    vecs.push_back(mk(8,1,  0,0,  0,0,0,  1,0,0,0,0));
    vecs.push_back(mk(8,1,  0,0,  0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(8,1,  0,0,  0,0,0,  0,3,0,0,0));
    // alu-use, then same operand on rs and rt
    vecs.push_back(mk(0,0,  0,0,  5,2,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,  5,1,  0,0,0,  0,0,0,0,1));
    vecs.push_back(mk(0,0,  5,1,  0,0,0,  0,0,2,0,0));
    vecs.push_back(mk(5,0,  5,0,  0,0,0,  0,3,3,0,0));
    // youngest match wins over an older not-ready copy
    vecs.push_back(mk(0,0,  0,0,  9,4,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,  0,0,  9,1,0,  0,0,0,0,0));
    vecs.push_back(mk(9,0,  0,0,  0,0,0,  0,1,0,0,0));
    // register 0 never matches a valid a3=0 entry
    vecs.push_back(mk(0,0,  0,0,  0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,  9,0,  0,0,0,  0,0,3,0,0));
    // flush inserts a bubble
    vecs.push_back(mk(0,0,  0,0,  7,1,1,  0,0,0,0,0));
    vecs.push_back(mk(7,0,  7,0,  0,0,0,  0,0,0,0,0));
    // flush together with stall
    vecs.push_back(mk(0,0,  0,0,  6,3,0,  0,0,0,0,0));
    vecs.push_back(mk(6,0,  0,0,  6,3,1,  1,0,0,0,0));
    vecs.push_back(mk(6,0,  0,0,  0,0,0,  1,0,0,0,0));
    vecs.push_back(mk(6,0,  0,0,  0,0,0,  0,3,0,0,0));
    // tnew=0 saturates to rem=0
    vecs.push_back(mk(0,0,  0,0,  4,0,0,  0,0,0,0,0));
    vecs.push_back(mk(4,0,  0,0,  0,0,0,  0,1,0,0,0));

    @(negedge clk);
    #1 chk_all("in_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].x_stall, vecs[i].x_frs, vecs[i].x_frt,
                 vecs[i].x_prs, vecs[i].x_prt);
      @(negedge clk);
    end

    // asynchronous reset while a load-use stall is active
    drive(mk(0,0, 0,0, 8,3,0, 0,0,0,0,0));
    @(negedge clk);
    drive(mk(8,0, 8,0, 0,0,0, 0,0,0,0,0));
    #1 chk("pre_reset.stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk_all("held_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1 chk_all("post_reset_empty", 0, 0, 0, 0, 0);
    @(negedge clk);

`ifdef HAZ_MDU_STALL_EN
    drive(mk(0,0, 0,0, 0,0,0, 0,0,0,0,0));
    e_md_start = 1'b1; e_md_div = 1'b1; d_isdm = 1'b0;
    #1 chk("md_issue.stall", 32'(stall), 32'd0);
    chk("md_issue.busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    e_md_start = 1'b0; e_md_div = 1'b0; d_isdm = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1 chk($sformatf("md%0d.stall", i), 32'(stall), 32'(i < 10));
      chk($sformatf("md%0d.busy", i), 32'(md_busy), 32'(i < 10));
      @(negedge clk);
    end
    d_isdm = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
